// File: rtl/l1_external_port_arbiter_pkg.sv
// Shared definitions for the L1 external port arbiter: command codes,
// FSM state encoding, owner encoding and a saturating-increment helper.
package l1_external_port_arbiter_pkg;

  // Cache command codes; anything other than CMD_FETCH is handled as a writeback.
  localparam logic [2:0] CMD_FETCH     = 3'b001;
  localparam logic [2:0] CMD_WRITEBACK = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/l1_external_port_arbiter_rr.sv
// rr_arbiter_2: combinational two-way round-robin grant between the
// instruction and data caches, plus the register remembering the last winner.
module rr_arbiter_2
  import l1_external_port_arbiter_pkg::*;
(
  input  logic   clock_i,
  input  logic   resetn_i,
  input  logic   req_inst_i,
  input  logic   req_data_i,
  input  logic   accept_i,
  output logic   grant_valid_o,
  output owner_e grant_owner_o
);

  owner_e last_grant_q, last_grant_d;

  // Grant the lone requester; on a tie, the one that did not win last time.
  always_comb begin
    grant_valid_o = req_inst_i | req_data_i;
    grant_owner_o = OWNER_INST;
    if (req_inst_i && req_data_i) begin
      grant_owner_o = (last_grant_q == OWNER_DATA) ? OWNER_INST : OWNER_DATA;
    end else if (req_data_i) begin
      grant_owner_o = OWNER_DATA;
    end
    last_grant_d = accept_i ? grant_owner_o : last_grant_q;
  end

  // Last winner; resets to data so the instruction cache wins the first tie.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      last_grant_q <= OWNER_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/l1_external_port_arbiter.sv
// l1_external_port_arbiter: shares one next-level memory port between the
// L1 instruction and data caches. One block transaction in flight at a time;
// fetch responses are steered back to the cache that issued the fetch.
// Optional feature: define ARB_PERF_COUNTERS_EN to add grant/wait counters.
module l1_external_port_arbiter
  import l1_external_port_arbiter_pkg::*;
#(
  parameter int BW_USED_ADDR_WORD    = 24,
  parameter int BW_DATA_EXTERNAL_BUS = 512,
  parameter int BW_CACHE_COMMAND     = 3
) (
  input  logic                            clock_i,
  input  logic                            resetn_i,
  // instruction cache side
  input  logic                            inst_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     inst_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    inst_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] inst_data_i,
  output logic                            inst_full_o,
  output logic                            inst_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     inst_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    inst_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] inst_data_o,
  input  logic                            inst_full_i,
  // data cache side
  input  logic                            data_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     data_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    data_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] data_data_i,
  output logic                            data_full_o,
  output logic                            data_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     data_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    data_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] data_data_o,
  input  logic                            data_full_i,
  // next-level memory side
  output logic                            down_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     down_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    down_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] down_data_o,
  input  logic                            down_full_i,
  input  logic                            down_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     down_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    down_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] down_data_i,
  output logic                            down_full_o
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]                     perf_inst_grants_o,
  output logic [31:0]                     perf_data_grants_o,
  output logic [31:0]                     perf_inst_wait_o,
  output logic [31:0]                     perf_data_wait_o
`endif
);

  arb_state_e state_q, state_d;
  owner_e     owner_q;

  // Captured request (driven downstream while in ISSUE).
  logic [BW_CACHE_COMMAND-1:0]     req_cmd_q;
  logic [BW_USED_ADDR_WORD-1:0]    req_addr_q;
  logic [BW_DATA_EXTERNAL_BUS-1:0] req_data_q;
  // Captured response (presented to the owner while in RESPOND).
  logic [BW_CACHE_COMMAND-1:0]     resp_cmd_q;
  logic [BW_USED_ADDR_WORD-1:0]    resp_addr_q;
  logic [BW_DATA_EXTERNAL_BUS-1:0] resp_data_q;

  logic   grant_valid;
  owner_e grant_owner;
  logic   accept;
  logic   cmd_is_fetch;
  logic   owner_ready;

  rr_arbiter_2 u_rr_arbiter_2 (
    .clock_i       (clock_i),
    .resetn_i      (resetn_i),
    .req_inst_i    (inst_write_i),
    .req_data_i    (data_write_i),
    .accept_i      (accept),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  assign cmd_is_fetch = (req_cmd_q == BW_CACHE_COMMAND'(CMD_FETCH));
  assign owner_ready  = (owner_q == OWNER_INST) ? !inst_full_i : !data_full_i;

  // Next-state and handshake outputs; everything defaults to "not ready / not valid".
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    inst_full_o  = 1'b1;
    data_full_o  = 1'b1;
    down_write_o = 1'b0;
    down_full_o  = 1'b1;
    inst_write_o = 1'b0;
    data_write_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        inst_full_o = !(grant_valid && (grant_owner == OWNER_INST));
        data_full_o = !(grant_valid && (grant_owner == OWNER_DATA));
        if (grant_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        down_write_o = 1'b1;
        if (!down_full_i) begin
          state_d = cmd_is_fetch ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        down_full_o = 1'b0;
        if (down_write_i) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        inst_write_o = (owner_q == OWNER_INST);
        data_write_o = (owner_q == OWNER_DATA);
        if (owner_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owner and transaction capture; reset discards anything in flight.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_INST;
      req_cmd_q   <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      resp_cmd_q  <= '0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant_owner;
        if (grant_owner == OWNER_INST) begin
          req_cmd_q  <= inst_command_i;
          req_addr_q <= inst_addr_i;
          req_data_q <= inst_data_i;
        end else begin
          req_cmd_q  <= data_command_i;
          req_addr_q <= data_addr_i;
          req_data_q <= data_data_i;
        end
      end
      if ((state_q == ST_WAIT) && down_write_i) begin
        resp_cmd_q  <= down_command_i;
        resp_addr_q <= down_addr_i;
        resp_data_q <= down_data_i;
      end
    end
  end

  // Request fields go downstream as captured; response fields go to both
  // caches unmodified, only the write strobe selects the owner.
  assign down_command_o = req_cmd_q;
  assign down_addr_o    = req_addr_q;
  assign down_data_o    = req_data_q;
  assign inst_command_o = resp_cmd_q;
  assign inst_addr_o    = resp_addr_q;
  assign inst_data_o    = resp_data_q;
  assign data_command_o = resp_cmd_q;
  assign data_addr_o    = resp_addr_q;
  assign data_data_o    = resp_data_q;

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] perf_inst_grants_q, perf_inst_grants_d;
  logic [31:0] perf_data_grants_q, perf_data_grants_d;
  logic [31:0] perf_inst_wait_q, perf_inst_wait_d;
  logic [31:0] perf_data_wait_q, perf_data_wait_d;

  // Count grants per requester and cycles a presented request is held off.
  always_comb begin
    perf_inst_grants_d = perf_inst_grants_q;
    perf_data_grants_d = perf_data_grants_q;
    perf_inst_wait_d   = perf_inst_wait_q;
    perf_data_wait_d   = perf_data_wait_q;
    if (accept && (grant_owner == OWNER_INST)) perf_inst_grants_d = sat_inc32(perf_inst_grants_q);
    if (accept && (grant_owner == OWNER_DATA)) perf_data_grants_d = sat_inc32(perf_data_grants_q);
    if (inst_write_i && inst_full_o) perf_inst_wait_d = sat_inc32(perf_inst_wait_q);
    if (data_write_i && data_full_o) perf_data_wait_d = sat_inc32(perf_data_wait_q);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      perf_inst_grants_q <= '0;
      perf_data_grants_q <= '0;
      perf_inst_wait_q   <= '0;
      perf_data_wait_q   <= '0;
    end else begin
      perf_inst_grants_q <= perf_inst_grants_d;
      perf_data_grants_q <= perf_data_grants_d;
      perf_inst_wait_q   <= perf_inst_wait_d;
      perf_data_wait_q   <= perf_data_wait_d;
    end
  end

  assign perf_inst_grants_o = perf_inst_grants_q;
  assign perf_data_grants_o = perf_data_grants_q;
  assign perf_inst_wait_o   = perf_inst_wait_q;
  assign perf_data_wait_o   = perf_data_wait_q;
`endif

endmodule
